// File: rtl/condicionador_entradas.sv
`default_nettype none
// ============================================================================
// Module      : condicionador_entradas
// Description : Input conditioning stage for the sequence game. The raw
//               buttons (botoes[3:0]) and the start button (jogar) each go
//               through a 2-FF synchroniser and a per-bit debounce counter.
//               A small FSM then turns the debounced button vector into a
//               single clean "jogada" event per press, and rejects presses
//               that involve more than one button.
//
// Ports       : clock          in   system clock, rising edge
//               reset          in   synchronous, active-high, clears all state
//               botoes[3:0]    in   raw buttons, asynchronous, active-high
//               jogar          in   raw start button, asynchronous, active-high
//               jogada_pulso   out  1-cycle pulse, valid single-button press
//               jogada_valor   out  one-hot value of the last accepted press
//               erro_multipla  out  1-cycle pulse, multi-button press seen
//               jogar_pulso    out  1-cycle pulse on debounced rise of jogar
//               db_botoes[3:0] out  debounced button vector
//               db_estado[3:0] out  FSM state code (0 solto, 1 press., 2 inv.)
//
// Revision    : 1.0 - initial release
// ============================================================================
module condicionador_entradas #(
    parameter int DEB_CICLOS = 50000,
    parameter int CNT_W      = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] botoes,
    input  logic       jogar,
    output logic       jogada_pulso,
    output logic [3:0] jogada_valor,
    output logic       erro_multipla,
    output logic       jogar_pulso,
    output logic [3:0] db_botoes,
    output logic [3:0] db_estado
);

    // Bits 3..0 are the game buttons, bit 4 is jogar.
    localparam int c_nbits = 5;

    // A debounced bit changes when its counter has already seen
    // DEB_CICLOS-1 mismatches and the current cycle is yet another one,
    // i.e. after DEB_CICLOS consecutive mismatching cycles.
    localparam logic [CNT_W-1:0] c_deb_lim = CNT_W'(DEB_CICLOS - 1);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    localparam logic [1:0] c_solto       = 2'd0;
    localparam logic [1:0] c_pressionado = 2'd1;
    localparam logic [1:0] c_invalido    = 2'd2;

    logic [c_nbits-1:0] w_raw;
    logic [c_nbits-1:0] r_sync1;
    logic [c_nbits-1:0] r_sync2;
    logic [c_nbits-1:0] w_deb;

    logic               r_deb_jogar_q;
    logic               r_jogar_pulso;

    logic [1:0]         r_estado;
    logic               r_jogada_pulso;
    logic               r_erro_multipla;
    logic [3:0]         r_jogada_valor;

    logic [3:0]         w_d;
    logic               w_d_onehot;

    assign w_raw = {jogar, botoes};

    // ------------------------------------------------------------------
    // Two-stage synchroniser for all asynchronous inputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------
    // Independent debounce per bit. The counter only runs while the
    // synchronised value disagrees with the debounced one, so any glitch
    // shorter than DEB_CICLOS cycles resets it and never propagates.
    // The limit compare (>=) keeps the counter from ever wrapping.
    // ------------------------------------------------------------------
    generate
        for (genvar g = 0; g < c_nbits; g++) begin : g_debounce
            logic [CNT_W-1:0] r_cnt;
            logic             r_deb_bit;

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_cnt     <= '0;
                    r_deb_bit <= 1'b0;
                end else if (r_sync2[g] == r_deb_bit) begin
                    r_cnt <= '0;
                end else if (r_cnt >= c_deb_lim) begin
                    r_deb_bit <= r_sync2[g];
                    r_cnt     <= '0;
                end else begin
                    r_cnt <= r_cnt + c_cnt_one;
                end
            end

            assign w_deb[g] = r_deb_bit;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Start button: registered rising-edge detector on the debounced bit.
    // Independent of the button FSM, so it may coincide with jogada_pulso.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_deb_jogar_q <= 1'b0;
            r_jogar_pulso <= 1'b0;
        end else begin
            r_deb_jogar_q <= w_deb[4];
            r_jogar_pulso <= w_deb[4] & ~r_deb_jogar_q;
        end
    end

    // ------------------------------------------------------------------
    // Press-classification FSM on the debounced button vector.
    // ------------------------------------------------------------------
    assign w_d        = w_deb[3:0];
    assign w_d_onehot = (w_d != 4'd0) && ((w_d & (w_d - 4'd1)) == 4'd0);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado        <= c_solto;
            r_jogada_pulso  <= 1'b0;
            r_erro_multipla <= 1'b0;
            r_jogada_valor  <= 4'd0;
        end else begin
            // Pulses are high for exactly the cycle after a transition.
            r_jogada_pulso  <= 1'b0;
            r_erro_multipla <= 1'b0;
            case (r_estado)
                c_solto: begin
                    if (w_d_onehot) begin
                        r_estado       <= c_pressionado;
                        r_jogada_pulso <= 1'b1;
                        r_jogada_valor <= w_d;
                    end else if (w_d != 4'd0) begin
                        // Two or more buttons became stable on the same
                        // cycle: treat as an invalid multiple press.
                        r_estado        <= c_invalido;
                        r_erro_multipla <= 1'b1;
                    end
                end
                c_pressionado: begin
                    if (w_d == 4'd0) begin
                        r_estado <= c_solto;
                    end else if (w_d != r_jogada_valor) begin
                        // Button added or swapped without a release; the
                        // already accepted value is kept.
                        r_estado        <= c_invalido;
                        r_erro_multipla <= 1'b1;
                    end
                end
                c_invalido: begin
                    if (w_d == 4'd0) begin
                        r_estado <= c_solto;
                    end
                end
                default: begin
                    r_estado <= c_solto;
                end
            endcase
        end
    end

    assign jogada_pulso  = r_jogada_pulso;
    assign jogada_valor  = r_jogada_valor;
    assign erro_multipla = r_erro_multipla;
    assign jogar_pulso   = r_jogar_pulso;
    assign db_botoes     = w_deb[3:0];
    assign db_estado     = {2'b00, r_estado};

endmodule
`default_nettype wire

// File: tb/tb_condicionador_entradas.sv
`default_nettype none
// ============================================================================
// Module      : tb_condicionador_entradas
// Description : Self-checking bench for condicionador_entradas with
//               DEB_CICLOS=4. Directed scenarios followed by randomised
//               button activity, compared every cycle against a
//               behavioural model of the input stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_condicionador_entradas;

    localparam int DEB = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] botoes;
    logic       jogar;
    logic       jogada_pulso;
    logic [3:0] jogada_valor;
    logic       erro_multipla;
    logic       jogar_pulso;
    logic [3:0] db_botoes;
    logic [3:0] db_estado;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [4:0] m_q[$];    // input samples still inside the synchroniser
    logic [4:0] m_win[$];  // last DEB synchronised samples
    logic [4:0] m_deb;
    logic       m_jogar_prev;
    int         m_phase;
    logic       m_jp;
    logic       m_err;
    logic       m_jogp;
    logic [3:0] m_val;

    condicionador_entradas #(
        .DEB_CICLOS (DEB),
        .CNT_W      (4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .botoes        (botoes),
        .jogar         (jogar),
        .jogada_pulso  (jogada_pulso),
        .jogada_valor  (jogada_valor),
        .erro_multipla (erro_multipla),
        .jogar_pulso   (jogar_pulso),
        .db_botoes     (db_botoes),
        .db_estado     (db_estado)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One rising edge of the model. A synchronised sample is the input seen
    // two edges earlier; a debounced bit flips once its last DEB
    // synchronised samples all disagree with it. The press rules act on the
    // debounced vector as it stood before this edge.
    task automatic model_edge(input logic r, input logic [4:0] in_v);
        logic [4:0] cmp;
        logic [3:0] d;
        logic [4:0] nd;
        bit         all_diff;
        if (r) begin
            m_q          = '{5'd0, 5'd0};
            m_win.delete();
            m_deb        = '0;
            m_jogar_prev = 1'b0;
            m_phase      = 0;
            m_jp         = 1'b0;
            m_err        = 1'b0;
            m_jogp       = 1'b0;
            m_val        = 4'd0;
            return;
        end
        cmp = m_q[1];
        m_q.push_front(in_v);
        void'(m_q.pop_back());

        d            = m_deb[3:0];
        m_jogp       = m_deb[4] && !m_jogar_prev;
        m_jogar_prev = m_deb[4];
        m_jp         = 1'b0;
        m_err        = 1'b0;
        if (m_phase == 0) begin
            if ($countones(d) == 1) begin
                m_phase = 1; m_jp = 1'b1; m_val = d;
            end else if ($countones(d) > 1) begin
                m_phase = 2; m_err = 1'b1;
            end
        end else if (m_phase == 1) begin
            if (d == 4'd0) m_phase = 0;
            else if (d != m_val) begin
                m_phase = 2; m_err = 1'b1;
            end
        end else begin
            if (d == 4'd0) m_phase = 0;
        end

        m_win.push_back(cmp);
        if (m_win.size() > DEB) void'(m_win.pop_front());
        nd = m_deb;
        if (m_win.size() == DEB) begin
            for (int b = 0; b < 5; b++) begin
                all_diff = 1'b1;
                for (int j = 0; j < DEB; j++)
                    if (m_win[j][b] == m_deb[b]) all_diff = 1'b0;
                if (all_diff) nd[b] = ~m_deb[b];
            end
        end
        m_deb = nd;
    endtask

    // Advance one clock, update the model with what the DUT sampled, and
    // compare every output one time unit after the edge.
    task automatic tick();
        logic       r;
        logic [4:0] iv;
        r  = reset;
        iv = {jogar, botoes};
        @(posedge clock);
        #1;
        model_edge(r, iv);
        chk("jogada_pulso",  {7'd0, jogada_pulso},  {7'd0, m_jp});
        chk("jogada_valor",  {4'd0, jogada_valor},  {4'd0, m_val});
        chk("erro_multipla", {7'd0, erro_multipla}, {7'd0, m_err});
        chk("jogar_pulso",   {7'd0, jogar_pulso},   {7'd0, m_jogp});
        chk("db_botoes",     {4'd0, db_botoes},     {4'd0, m_deb[3:0]});
        chk("db_estado",     {4'd0, db_estado},     8'(m_phase));
        chk("pulse_excl",    {7'd0, jogada_pulso & erro_multipla}, 8'd0);
    endtask

    initial begin
        int first_pulse;
        int n_jp;
        int n_err;
        int n_jogp;
        int max_db;
        int hold;
        int sel;

        // 1: reset held three cycles with all inputs low
        reset  = 1'b1;
        botoes = 4'd0;
        jogar  = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("t1_valor", {4'd0, jogada_valor}, 8'd0);
        chk("t1_estado", {4'd0, db_estado}, 8'd0);

        // 2: single button pressed, held, released
        reset       = 1'b0;
        botoes      = 4'b0100;
        first_pulse = -1;
        n_jp        = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (jogada_pulso) begin
                n_jp++;
                if (first_pulse < 0) first_pulse = i;
            end
            if (i == 10) chk("t2_estado_held", {4'd0, db_estado}, 8'd1);
        end
        chk("t2_pulse_edge", 8'(first_pulse), 8'd7);
        chk("t2_pulse_count", 8'(n_jp), 8'd1);
        chk("t2_valor", {4'd0, jogada_valor}, 8'b0100);
        botoes = 4'd0;
        for (int i = 0; i < 10; i++) tick();
        chk("t2_estado_rel", {4'd0, db_estado}, 8'd0);
        chk("t2_valor_rel", {4'd0, jogada_valor}, 8'b0100);

        // 3: glitch shorter than the debounce window
        botoes = 4'b0001;
        n_jp   = 0;
        max_db = 0;
        for (int i = 0; i < 13; i++) begin
            if (i == 3) botoes = 4'd0;
            tick();
            if (jogada_pulso) n_jp++;
            if (int'(db_botoes) > max_db) max_db = int'(db_botoes);
        end
        chk("t3_no_pulse", 8'(n_jp), 8'd0);
        chk("t3_db_zero", 8'(max_db), 8'd0);
        chk("t3_estado", {4'd0, db_estado}, 8'd0);

        // 4: two buttons pressed together
        botoes = 4'b0011;
        n_jp   = 0;
        n_err  = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (jogada_pulso) n_jp++;
            if (erro_multipla) n_err++;
        end
        chk("t4_err_count", 8'(n_err), 8'd1);
        chk("t4_no_jogada", 8'(n_jp), 8'd0);
        chk("t4_estado_inv", {4'd0, db_estado}, 8'd2);
        botoes = 4'd0;
        for (int i = 0; i < 10; i++) tick();
        chk("t4_estado_rel", {4'd0, db_estado}, 8'd0);

        // 5: accepted press, then a second button added without release
        botoes = 4'b0001;
        for (int i = 0; i < 10; i++) tick();
        chk("t5_valor_acc", {4'd0, jogada_valor}, 8'b0001);
        botoes = 4'b0011;
        n_err  = 0;
        n_jp   = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (erro_multipla) n_err++;
            if (jogada_pulso) n_jp++;
        end
        chk("t5_err_count", 8'(n_err), 8'd1);
        chk("t5_no_jogada", 8'(n_jp), 8'd0);
        chk("t5_estado_inv", {4'd0, db_estado}, 8'd2);
        chk("t5_valor_kept", {4'd0, jogada_valor}, 8'b0001);
        botoes = 4'd0;
        for (int i = 0; i < 10; i++) tick();

        // 6: jogar with a held button, then reset in the middle of the press
        botoes = 4'b1000;
        jogar  = 1'b1;
        n_jogp = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (jogar_pulso) n_jogp++;
        end
        chk("t6_jogar_count", 8'(n_jogp), 8'd1);
        jogar = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) tick();
        chk("t6_rst_valor", {4'd0, jogada_valor}, 8'd0);
        chk("t6_rst_db", {4'd0, db_botoes}, 8'd0);
        chk("t6_rst_estado", {4'd0, db_estado}, 8'd0);
        reset       = 1'b0;
        first_pulse = -1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (jogada_pulso && first_pulse < 0) first_pulse = i;
        end
        chk("t6_reaccept_edge", 8'(first_pulse), 8'd7);
        chk("t6_reaccept_valor", {4'd0, jogada_valor}, 8'b1000);
        botoes = 4'd0;
        for (int i = 0; i < 10; i++) tick();

        // 7: randomised button and start activity with occasional resets
        for (int s = 0; s < 60; s++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 4)      botoes = 4'd0;
            else if (sel < 8) botoes = 4'(1 << (sel - 4));
            else              botoes = 4'($urandom_range(0, 15));
            jogar = 1'($urandom_range(0, 1));
            reset = ($urandom_range(0, 19) == 0);
            hold  = int'($urandom_range(1, 9));
            for (int i = 0; i < hold; i++) begin
                tick();
                reset = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
